// File: rtl/countdown_100.sv
// Loadable down-counter timer: counts a captured start value down to zero, pulses o_done, optional auto-reload.
// Latency: start in cycle N shows the load value in N+1; each prescaled tick then takes one off the count.
// Backpressure: none; i_pause freezes counting while high, i_abort returns to IDLE, starts are ignored while busy.
module countdown_100 #(
    parameter int CNT_W    = 7,
    parameter int MAX_VAL  = 99,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_pause,
    input  logic             i_abort,
    input  logic             i_auto_reload,
    output logic [CNT_W-1:0] o_value,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PS_W-1:0]  presc_q;
    logic [PS_W-1:0]  presc_d;
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] reload_d;
    logic [CNT_W-1:0] value_d;
    logic             done_d;
    logic             busy_d;
    logic [CNT_W-1:0] load_clamped;
    logic             count_en;
    logic             presc_wrap;

    // Clamp at full width so out-of-range loads saturate at MAX_VAL
    assign load_clamped = (i_load_value > MAX_V) ? MAX_V : i_load_value;
    // Counting happens in every busy cycle where pause is low; a pause-release
    // cycle already counts, so a pause held for P cycles costs exactly P cycles
    assign count_en     = (state_q != IDLE) && !i_pause;
    assign presc_wrap   = (presc_q == PS_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort beats start beats pause beats tick
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start && (load_clamped != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN, PAUSE: begin
                    if (i_pause) begin
                        state_d = PAUSE;
                    end else if (presc_wrap && (o_value == CNT_W'(1)) && !i_auto_reload) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath next values; a zero count while busy means an auto-reload is due
    always_comb begin
        value_d  = o_value;
        presc_d  = presc_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (i_abort) begin
            value_d = '0;
            presc_d = '0;
        end else if (state_q == IDLE) begin
            if (i_start) begin
                value_d  = load_clamped;
                reload_d = load_clamped;
                presc_d  = '0;
                done_d   = (load_clamped == '0);
            end
        end else if (count_en) begin
            if (o_value == '0) begin
                value_d = reload_q;
                presc_d = '0;
            end else if (presc_wrap) begin
                presc_d = '0;
                value_d = o_value - CNT_W'(1);
                done_d  = (o_value == CNT_W'(1));
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
        busy_d = (state_d != IDLE);
    end

    // Registered outputs and counters, busy updated alongside the state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_value  <= '0;
            presc_q  <= '0;
            reload_q <= '0;
            o_done   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_value  <= value_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            o_done   <= done_d;
            o_busy   <= busy_d;
        end
    end

    assign o_state = state_q;

endmodule
